alu_carry_sequencer: RTL and testbench
======================================

// Module: alu_carry_sequencer
// PURPOSE
//   Multi-cycle wide add/subtract controller built around the 8-bit carry-lookahead slice.
//   Latches two NB-byte operands and walks them one byte lane per cycle, least significant lane first.
//   Each cycle it drives P/G/C_IN to an external alu_lookahead instance and chains CARRYS[7] into the next lane.
//   Returns the sum plus C/V/Z flags with a START/BUSY/DONE handshake. It sits between the microcode sequencer and the ALU slice.
// PARAMETERS
//   NB   4   number of byte lanes; operand width = 8*NB bits; legal 1..16
// PORTS
//   CLK        in   1      rising-edge clock
//   RST        in   1      asynchronous reset, active-high
//   START      in   1      request: latch operands and begin (honoured only when not BUSY)
//   OP_SUB     in   1      0 = A+B+C_IN, 1 = A-B (A + ~B + 1; C_IN ignored)
//   C_IN       in   1      carry into lane 0 for add
//   A          in   8*NB   operand A, sampled on accepted START
//   B          in   8*NB   operand B, sampled on accepted START
//   LA_CARRYS  in   8      CARRYS from lookahead slice (combinational from LA_* outputs)
//   LA_C_IN    out  1      carry into current lane
//   LA_P       out  8      propagate of current lane = a_byte ^ b_byte
//   LA_G       out  8      generate of current lane = a_byte & b_byte
//   BUSY       out  1      high while lanes are being processed
//   DONE       out  1      one-cycle pulse: RESULT and flags valid and updated
//   RESULT     out  8*NB   sum/difference, held until next DONE
//   C_OUT      out  1      carry out of MSB lane (sub: 1 = no borrow)
//   V_OUT      out  1      signed overflow = carry into bit 8*NB-1 ^ C_OUT
//   Z_OUT      out  1      RESULT == 0
// BEHAVIOUR
//   Reset: asynchronous. State=IDLE; lane counter=0; carry reg=0.
//   Reset: all outputs 0, including RESULT, flags and LA_*.
//   Reset mid-RUN aborts the operation; no DONE is produced.
//   FSM: IDLE -> RUN on START. RUN stays for NB cycles (lane 0..NB-1). RUN -> FIN after lane NB-1. FIN -> IDLE, or -> RUN if START.
//   START acceptance: START sampled high in IDLE or FIN starts an operation.
//   At acceptance the block latches A, B^{8*NB{OP_SUB}}, carry = OP_SUB ? 1 : C_IN, and sets lane=0.
//   START while in RUN is ignored entirely; latched operands are not disturbed.
//   RUN, lane i: LA_P/LA_G come from latched byte i of each operand; LA_C_IN = carry reg.
//   RUN, lane i: sum byte = LA_P ^ {LA_CARRYS[6:0], LA_C_IN}, registered into the result shadow byte i.
//   RUN, lane i: carry reg <= LA_CARRYS[7]; lane <= lane+1.
//   Last lane (i = NB-1): C_OUT <= LA_CARRYS[7]; V_OUT <= LA_CARRYS[6] ^ LA_CARRYS[7].
//   At that same edge, RESULT is updated from the shadow bytes plus the final byte.
//   Z_OUT is computed on the complete new RESULT. RESULT, C_OUT, V_OUT and Z_OUT update only at this edge.
//   LA_P, LA_G and LA_C_IN are 0 outside RUN.
//   BUSY = (state==RUN). DONE = (state==FIN), high for exactly one cycle.
//   Latency: START accepted at edge k -> BUSY high for cycles k+1..k+NB -> DONE high for cycle k+NB+1. Throughput: one op per NB+1 cycles.
//   Back-to-back: START during the DONE cycle is accepted; BUSY rises the next cycle with no IDLE gap.
//   Lane counter width is clog2(NB), minimum 1. It never exceeds NB-1 and wraps to 0 on every accepted START.
//   NB=1: RUN lasts one cycle.
//   Outputs are registered except LA_P, LA_G and LA_C_IN, which are combinational from registered state.
// TESTING (NB=4)
//   ADD A=0x000000FF, B=0x00000001, C_IN=0, START at cycle 0 -> BUSY cycles 1-4, DONE cycle 5; RESULT=0x00000100, C=0, V=0, Z=0.
//   ADD A=0xFFFFFFFF, B=0x00000001, C_IN=0 -> RESULT=0x00000000, C=1, V=0, Z=1; lanes 1-3 see LA_C_IN=1.
//   SUB A=0x80000000, B=0x00000001 -> RESULT=0x7FFFFFFF, C=1, V=1, Z=0.
//   ADD 0x12345678+0x11111111; START pulsed again with other operands during cycle 2 -> ignored; DONE once, RESULT=0x23456789.
//   RST high during lane 2 -> immediately BUSY=0, DONE=0, RESULT=0, LA_*=0; after release, START 0x1+0x1 -> RESULT=0x2.
//   START held continuously with ADD 1+1 -> DONE at cycles 5, 10, 15; BUSY never low between ops except the DONE cycle; formal: LA_* == 0 whenever !BUSY.

Source files
------------

// File: rtl/alu_carry_sequencer.sv
// Multi-cycle wide add/subtract controller driving an external 8-bit lookahead slice.
// Operands are walked one byte lane per cycle, LSB lane first, chaining the slice carry.
module alu_carry_sequencer #(
    parameter int unsigned NB = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_op_sub,
    input  logic            i_c_in,
    input  logic [8*NB-1:0] i_a,
    input  logic [8*NB-1:0] i_b,
    input  logic [7:0]      i_la_carrys,
    output logic            o_la_c_in,
    output logic [7:0]      o_la_p,
    output logic [7:0]      o_la_g,
    output logic            o_busy,
    output logic            o_done,
    output logic [8*NB-1:0] o_result,
    output logic            o_c_out,
    output logic            o_v_out,
    output logic            o_z_out
);

    localparam int unsigned W  = 8 * NB;
    localparam int unsigned LW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(NB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [LW-1:0]   r_lane;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_shadow;
    logic [W-1:0]    r_result;
    logic            r_busy;
    logic            r_done;
    logic            r_c_out;
    logic            r_v_out;
    logic            r_z_out;

    logic            w_run;
    logic [LW+2:0]   w_shift;
    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [7:0]      w_p;
    logic [7:0]      w_sum;
    logic [W-1:0]    w_shadow_next;

    // Current lane byte selection and sum/shadow merge
    always_comb begin
        w_run         = (r_state == ST_RUN);
        w_shift       = {r_lane, 3'b000};
        w_a_byte      = 8'(r_a >> w_shift);
        w_b_byte      = 8'(r_b >> w_shift);
        w_p           = w_a_byte ^ w_b_byte;
        w_sum         = w_p ^ {i_la_carrys[6:0], r_carry};
        w_shadow_next = (r_shadow & ~(W'(8'hFF) << w_shift)) | (W'(w_sum) << w_shift);
    end

    // Lookahead slice drive, forced to zero outside RUN
    assign o_la_p    = w_run ? w_p : 8'h00;
    assign o_la_g    = w_run ? (w_a_byte & w_b_byte) : 8'h00;
    assign o_la_c_in = w_run ? r_carry : 1'b0;

    // Sequencer FSM with registered handshake, result and flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_lane   <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_c_out  <= 1'b0;
            r_v_out  <= 1'b0;
            r_z_out  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b ^ {W{i_op_sub}};
                        r_carry <= i_op_sub ? 1'b1 : i_c_in;
                        r_lane  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_shadow <= w_shadow_next;
                    r_carry  <= i_la_carrys[7];
                    if (r_lane == LAST_LANE) begin
                        r_result <= w_shadow_next;
                        r_c_out  <= i_la_carrys[7];
                        r_v_out  <= i_la_carrys[6] ^ i_la_carrys[7];
                        r_z_out  <= (w_shadow_next == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_FIN;
                    end else begin
                        r_lane   <= r_lane + LW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_c_out  = r_c_out;
    assign o_v_out  = r_v_out;
    assign o_z_out  = r_z_out;

endmodule

// File: tb/tb_alu_carry_sequencer.sv
// Directed bench for alu_carry_sequencer (NB=4) with a behavioural lookahead slice.
module tb_alu_carry_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic        c_in;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  la_carrys;
    logic        la_c_in;
    logic [7:0]  la_p;
    logic [7:0]  la_g;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        c_out;
    logic        v_out;
    logic        z_out;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  lane_cin;
    logic [7:0]  p0;
    logic [7:0]  g0;
    logic        chain_c;

    alu_carry_sequencer #(.NB(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_op_sub    (op_sub),
        .i_c_in      (c_in),
        .i_a         (a),
        .i_b         (b),
        .i_la_carrys (la_carrys),
        .o_la_c_in   (la_c_in),
        .o_la_p      (la_p),
        .o_la_g      (la_g),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_c_out     (c_out),
        .o_v_out     (v_out),
        .o_z_out     (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ripple model of the external lookahead slice
    always_comb begin
        chain_c   = la_c_in;
        la_carrys = 8'h00;
        for (int i = 0; i < 8; i++) begin
            la_carrys[i] = la_g[i] | (la_p[i] & chain_c);
            chain_c      = la_carrys[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it through RUN into the DONE cycle
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic sub,
                         input logic cin, output logic [3:0] cins,
                         output logic [7:0] lp0, output logic [7:0] lg0);
        a = ta; b = tb; op_sub = sub; c_in = cin; start = 1'b1;
        tick();
        start = 1'b0;
        lp0 = la_p;
        lg0 = la_g;
        for (int l = 0; l < 4; l++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            cins[l] = la_c_in;
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fin", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_done",   32'(done),    32'd0);
        chk("rst_result", result,       32'd0);
        chk("rst_flags",  32'({c_out, v_out, z_out}), 32'd0);
        chk("rst_la",     32'({la_c_in, la_p, la_g}), 32'd0);
        rst = 1'b0;
        tick();

        // 0xFF + 0x01: carry ripples out of lane 0 only
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lane_cin, p0, g0);
        chk("t1_p0",     32'(p0),       32'h000000FE);
        chk("t1_g0",     32'(g0),       32'h00000001);
        chk("t1_cins",   32'(lane_cin), 32'h00000002);
        chk("t1_result", result,        32'h00000100);
        chk("t1_flags",  32'({c_out, v_out, z_out}), 32'b000);
        tick();
        chk("t1_idle",   32'({busy, done}), 32'd0);
        chk("t1_la_idle", 32'({la_c_in, la_p, la_g}), 32'd0);

        // 0xFFFFFFFF + 1: wraps to zero, carry into lanes 1-3
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lane_cin, p0, g0);
        chk("t2_cins",   32'(lane_cin), 32'h0000000E);
        chk("t2_result", result,        32'h00000000);
        chk("t2_flags",  32'({c_out, v_out, z_out}), 32'b101);
        tick();

        // 0x80000000 - 1: signed overflow, no borrow; c_in must be ignored
        do_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, lane_cin, p0, g0);
        chk("t3_cin0",   32'(lane_cin[0]), 32'd1);
        chk("t3_result", result,        32'h7FFFFFFF);
        chk("t3_flags",  32'({c_out, v_out, z_out}), 32'b110);
        tick();

        // ADD with carry-in
        do_op(32'h00000010, 32'h00000020, 1'b0, 1'b1, lane_cin, p0, g0);
        chk("t3b_result", result,       32'h00000031);
        tick();

        // START during RUN is ignored
        a = 32'h12345678; b = 32'h11111111; op_sub = 1'b0; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_busy1", 32'(busy), 32'd1);
        tick();
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op_sub = 1'b1; c_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_busy3", 32'({busy, done}), 32'b10);
        tick();
        chk("t4_busy4", 32'({busy, done}), 32'b10);
        tick();
        chk("t4_done5", 32'({busy, done}), 32'b01);
        chk("t4_result", result, 32'h23456789);
        chk("t4_flags",  32'({c_out, v_out, z_out}), 32'b000);
        tick();
        chk("t4_single_done", 32'({busy, done}), 32'b00);
        chk("t4_hold", result, 32'h23456789);

        // Reset during lane 2 aborts the operation
        a = 32'hFFFFFFFF; b = 32'h00000000; op_sub = 1'b0; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5_lane2_p",   32'(la_p),    32'h000000FF);
        chk("t5_lane2_cin", 32'(la_c_in), 32'd0);
        rst = 1'b1;
        #1;
        chk("t5_rst_bd",     32'({busy, done}), 32'd0);
        chk("t5_rst_result", result, 32'd0);
        chk("t5_rst_la",     32'({la_c_in, la_p, la_g}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("t5_no_done", 32'({busy, done}), 32'd0);
        do_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, lane_cin, p0, g0);
        chk("t5_result", result, 32'h00000002);
        tick();

        // START held: back-to-back ops with DONE every 5 cycles
        a = 32'h00000001; b = 32'h00000001; op_sub = 1'b0; c_in = 1'b0; start = 1'b1;
        tick();
        for (int c = 1; c <= 15; c++) begin
            if (c % 5 == 0) begin
                chk("t6_done", 32'({busy, done}), 32'b01);
                chk("t6_la_zero", 32'({la_c_in, la_p, la_g}), 32'd0);
                chk("t6_result", result, 32'h00000002);
            end else begin
                chk("t6_busy", 32'({busy, done}), 32'b10);
            end
            if (c == 15) start = 1'b0;
            tick();
        end
        chk("t6_idle", 32'({busy, done}), 32'd0);
        chk("t6_la_idle", 32'({la_c_in, la_p, la_g}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
